// File: rtl/tpram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpram_pkg
// Description : Shared access-mode encodings and sizing helpers for the
//               two-port RAM FIFO wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
package tpram_pkg;

  localparam int c_BYTE_W = 8;

  // Access width encoding shared by the write and read mode inputs
  typedef enum logic [1:0] {
    MODE_DWORD = 2'b00,
    MODE_WORD  = 2'b01,
    MODE_BYTE  = 2'b10,
    MODE_RESV  = 2'b11
  } tpram_mode_e;

  // Bytes moved by one access; the reserved code behaves as a dword
  function automatic logic [2:0] size_of(input logic [1:0] mode);
    case (tpram_mode_e'(mode))
      MODE_WORD: return 3'd2;
      MODE_BYTE: return 3'd1;
      default:   return 3'd4;
    endcase
  endfunction

  // FIFO capacity in bytes for a RAM of depth rows by ram_w bits
  function automatic int capacity(input int depth, input int ram_w);
    return depth * ram_w / c_BYTE_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tpram_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : tpram_lane_align
// Description : Combinational byte-lane rotate and mask for one RAM row.
//               READ=0: rotate access data up to the byte offset and produce
//               the row byte enables. READ=1: rotate the row down so the
//               addressed byte lands in byte 0 and zero bytes past the size.
// Revision    : 1.0 - initial release
// ============================================================================
module tpram_lane_align
  import tpram_pkg::*;
#(
  parameter int  RAM_W   = 64,
  parameter bit  READ    = 1'b0,
  localparam int c_NB    = RAM_W / c_BYTE_W,
  localparam int c_OFF_W = $clog2(c_NB)
) (
  input  logic [RAM_W-1:0]   i_row,
  input  logic [c_OFF_W-1:0] i_off,
  input  logic [2:0]         i_size,
  input  logic               i_clip,
  output logic [RAM_W-1:0]   o_row,
  output logic [c_NB-1:0]    o_be
);

  for (genvar b = 0; b < c_NB; b++) begin : g_byte
    logic [c_OFF_W-1:0] w_src;
    logic [c_OFF_W-1:0] w_rel;
    logic [c_OFF_W:0]   w_end;
    logic               w_en;

    // w_rel is this byte's position within the access, w_src the row byte feeding it
    if (READ) begin : g_rd
      assign w_src = c_OFF_W'(b) + i_off;
      assign w_rel = c_OFF_W'(b);
    end else begin : g_wr
      assign w_src = c_OFF_W'(b) - i_off;
      assign w_rel = c_OFF_W'(b) - i_off;
    end

    // Carry out of offset+position means the byte wrapped past the row end
    assign w_end   = {1'b0, i_off} + {1'b0, w_rel};
    assign w_en    = (32'(i_size) > 32'(w_rel)) && !(i_clip && w_end[c_OFF_W]);
    assign o_be[b] = w_en;
    assign o_row[b*c_BYTE_W +: c_BYTE_W] = w_en ? i_row[{w_src, 3'b000} +: c_BYTE_W] : 8'h00;
  end

endmodule
`default_nettype wire

// File: rtl/tpram_fifo_wrap.sv
`default_nettype none
// ============================================================================
// Module      : tpram_fifo_wrap
// Description : Two-port RAM wrapper for the eFPGA / math-block path.
//               Random-access mode with byte/half/word lane-aligned access,
//               or FIFO mode with auto-incrementing byte pointers, occupancy
//               level and sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tpram_fifo_wrap
  import tpram_pkg::*;
#(
  parameter int  DATA_W = 32,
  parameter int  RAM_W  = 64,
  parameter int  DEPTH  = 512,
  localparam int AW     = $clog2(DEPTH * RAM_W / 8)
) (
  input  logic              EFPGA_TPRAM_CLK,
  input  logic              EFPGA_TPRAM_RSTN,
  input  logic              EFPGA_TPRAM_FIFO_EN,
  input  logic              EFPGA_TPRAM_FLUSH,
  input  logic [1:0]        EFPGA_TPRAM_W_MODE,
  input  logic [1:0]        EFPGA_TPRAM_R_MODE,
  input  logic              EFPGA_TPRAM_WDSEL,
  input  logic              EFPGA_TPRAM_WE,
  input  logic [AW-1:0]     EFPGA_TPRAM_W_ADDR,
  input  logic [DATA_W-1:0] EFPGA_TPRAM_W_DATA,
  input  logic [DATA_W-1:0] MATHB_TPRAM_W_DATA,
  input  logic              EFPGA_TPRAM_RE,
  input  logic [AW-1:0]     EFPGA_TPRAM_R_ADDR,
  output logic [DATA_W-1:0] TPRAM_EFPGA_R_DATA,
  output logic [DATA_W-1:0] TPRAM_MATHB_R_DATA,
  output logic              TPRAM_R_VALID,
  output logic              TPRAM_W_READY,
  output logic [AW:0]       TPRAM_LEVEL,
  output logic              TPRAM_FULL,
  output logic              TPRAM_EMPTY,
  output logic              TPRAM_OVF,
  output logic              TPRAM_UDF
);

  localparam int          c_NB    = RAM_W / c_BYTE_W;
  localparam int          c_OFF_W = $clog2(c_NB);
  localparam int          c_ROW_W = AW - c_OFF_W;
  localparam int          c_LANES = RAM_W / DATA_W;
  localparam logic [AW:0] c_CAP   = (AW+1)'(capacity(DEPTH, RAM_W));

  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [AW:0]        r_level;
  logic               r_rvalid;
  logic               r_ovf;
  logic               r_udf;
  logic [c_OFF_W-1:0] r_rd_off;
  logic [2:0]         r_rd_size;

  logic               w_fifo;
  logic [2:0]         w_wsz;
  logic [2:0]         w_rsz;
  logic [AW:0]        w_wsz_l;
  logic [AW:0]        w_rsz_l;
  logic [AW:0]        w_room;
  logic               w_push_ok;
  logic               w_pop_ok;
  logic               w_w_ready;
  logic               w_wr_acc;
  logic               w_rd_acc;
  logic [AW:0]        w_level_nxt;
  logic [AW-1:0]      w_waddr;
  logic [AW-1:0]      w_raddr;
  logic [c_ROW_W-1:0] w_wrow_addr;
  logic [c_ROW_W-1:0] w_rrow_addr;
  logic [DATA_W-1:0]  w_wsrc;
  logic [RAM_W-1:0]   w_wrow;
  logic [c_NB-1:0]    w_wbe;
  logic [RAM_W-1:0]   w_ram_q;
  logic [RAM_W-1:0]   w_rrot;
  logic [c_NB-1:0]    w_rbe;
  logic               w_unused_rd;

  // Size decode; the math-block write path is always a full dword
  assign w_fifo  = EFPGA_TPRAM_FIFO_EN;
  assign w_wsz   = EFPGA_TPRAM_WDSEL ? 3'd4 : size_of(EFPGA_TPRAM_W_MODE);
  assign w_rsz   = size_of(EFPGA_TPRAM_R_MODE);
  assign w_wsz_l = (AW+1)'(w_wsz);
  assign w_rsz_l = (AW+1)'(w_rsz);

  // Occupancy checks use the registered level only, so a push never feeds a same-cycle pop
  assign w_room    = c_CAP - r_level;
  assign w_push_ok = (w_wsz_l <= w_room);
  assign w_pop_ok  = (r_level >= w_rsz_l);
  assign w_w_ready = !w_fifo || w_push_ok;

  // Flush takes priority over both request strobes
  assign w_wr_acc = EFPGA_TPRAM_WE && w_w_ready && !EFPGA_TPRAM_FLUSH;
  assign w_rd_acc = EFPGA_TPRAM_RE && !EFPGA_TPRAM_FLUSH && (!w_fifo || w_pop_ok);

  assign w_level_nxt = r_level + (w_wr_acc ? w_wsz_l : '0) - (w_rd_acc ? w_rsz_l : '0);

  assign w_waddr     = w_fifo ? r_wptr : EFPGA_TPRAM_W_ADDR;
  assign w_raddr     = w_fifo ? r_rptr : EFPGA_TPRAM_R_ADDR;
  assign w_wrow_addr = w_waddr[AW-1:c_OFF_W];
  assign w_rrow_addr = w_raddr[AW-1:c_OFF_W];
  assign w_wsrc      = EFPGA_TPRAM_WDSEL ? MATHB_TPRAM_W_DATA : EFPGA_TPRAM_W_DATA;

  // FIFO writes are clipped at the row end; random-mode writes wrap inside the row
  tpram_lane_align #(
    .RAM_W (RAM_W),
    .READ  (1'b0)
  ) u_wr_align (
    .i_row  (RAM_W'(w_wsrc)),
    .i_off  (w_waddr[c_OFF_W-1:0]),
    .i_size (w_wsz),
    .i_clip (w_fifo),
    .o_row  (w_wrow),
    .o_be   (w_wbe)
  );

`ifdef FPGA_EMULATION
  tpram_fpga_macro #(
    .WIDTH (RAM_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (EFPGA_TPRAM_CLK),
    .we    (w_wr_acc),
    .be    (w_wbe),
    .waddr (w_wrow_addr),
    .wdata (w_wrow),
    .re    (w_rd_acc),
    .raddr (w_rrow_addr),
    .rdata (w_ram_q)
  );
`else
  logic [RAM_W-1:0] r_mem [DEPTH];
  logic [RAM_W-1:0] r_ram_q;

  // Behavioural RAM write port with per-byte enables
  always_ff @(posedge EFPGA_TPRAM_CLK) begin
    if (w_wr_acc) begin
      for (int b = 0; b < c_NB; b++) begin
        if (w_wbe[b]) begin
          r_mem[w_wrow_addr][b*c_BYTE_W +: c_BYTE_W] <= w_wrow[b*c_BYTE_W +: c_BYTE_W];
        end
      end
    end
  end

  // Registered read port; a same-row write in this cycle is not yet visible
  always_ff @(posedge EFPGA_TPRAM_CLK) begin
    if (w_rd_acc) begin
      r_ram_q <= r_mem[w_rrow_addr];
    end
  end

  assign w_ram_q = r_ram_q;
`endif

  // Read capture: valid pulse plus the byte offset and size used to align the result
  always_ff @(posedge EFPGA_TPRAM_CLK or negedge EFPGA_TPRAM_RSTN) begin
    if (!EFPGA_TPRAM_RSTN) begin
      r_rvalid  <= 1'b0;
      r_rd_off  <= '0;
      r_rd_size <= '0;
    end else begin
      r_rvalid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_off  <= w_raddr[c_OFF_W-1:0];
        r_rd_size <= w_rsz;
      end
    end
  end

  // FIFO pointers, occupancy and sticky flags; untouched in random mode except by flush
  always_ff @(posedge EFPGA_TPRAM_CLK or negedge EFPGA_TPRAM_RSTN) begin
    if (!EFPGA_TPRAM_RSTN) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (EFPGA_TPRAM_FLUSH) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (w_fifo) begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + AW'(w_wsz);
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + AW'(w_rsz);
      end
      r_level <= w_level_nxt;
      if (EFPGA_TPRAM_WE && !w_push_ok) begin
        r_ovf <= 1'b1;
      end
      if (EFPGA_TPRAM_RE && !w_pop_ok) begin
        r_udf <= 1'b1;
      end
    end
  end

  // Read rotate: addressed byte to byte 0, wrapping inside the row, bytes past size zeroed
  tpram_lane_align #(
    .RAM_W (RAM_W),
    .READ  (1'b1)
  ) u_rd_align (
    .i_row  (w_ram_q),
    .i_off  (r_rd_off),
    .i_size (r_rd_size),
    .i_clip (1'b0),
    .o_row  (w_rrot),
    .o_be   (w_rbe)
  );

  assign TPRAM_EFPGA_R_DATA = w_rrot[DATA_W-1:0];

  // Math-block port sees the whole dword lane holding the captured offset
  if (c_LANES > 1) begin : g_lane_multi
    localparam int c_LANE_W = $clog2(c_LANES);
    logic [c_LANE_W-1:0] w_lane;
    assign w_lane             = r_rd_off[c_OFF_W-1 -: c_LANE_W];
    assign TPRAM_MATHB_R_DATA = w_ram_q[w_lane*DATA_W +: DATA_W];
  end else begin : g_lane_single
    assign TPRAM_MATHB_R_DATA = w_ram_q[DATA_W-1:0];
  end

  // Upper rotated bytes are always zero and the read enables only serve the write side
  assign w_unused_rd = &{1'b0, w_rbe, w_rrot};

  assign TPRAM_R_VALID = r_rvalid;
  assign TPRAM_W_READY = w_w_ready;
  assign TPRAM_LEVEL   = r_level;
  assign TPRAM_FULL    = (r_level == c_CAP);
  assign TPRAM_EMPTY   = (r_level == '0);
  assign TPRAM_OVF     = r_ovf;
  assign TPRAM_UDF     = r_udf;

endmodule
`default_nettype wire
